jtag_axi_arbiter: RTL and testbench
===================================

Name: jtag_axi_arbiter

Overview:
- Shares one 64-bit AXI master port among NREQ debug requesters, e.g. the JTAG register path and a second debug agent.
- Each requester issues single-beat load/store commands. The block arbitrates them round-robin, runs exactly one AXI transaction at a time, and returns the response to the originating requester.
- Sits between the debug requesters and the SoC AXI crossbar slave port.

Parameters:
NREQ, 2, number of requesters (2..8)
ADDR_W, 32, AXI address width
ID_W, 4, AXI ID width; every issued ID equals the requester index, zero-extended

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  NREQ  per-requester command valid
req_ready_o  out  NREQ  one-hot command accept pulse
req_we_i  in  NREQ  1 = store, 0 = load
req_addr_i  in  NREQ*ADDR_W  byte address; requester i occupies slice [i*ADDR_W +: ADDR_W]
req_wdata_i  in  NREQ*64  store data, sliced the same way
rsp_valid_o  out  NREQ  one-hot response pulse
rsp_rdata_o  out  64  load data, shared by all requesters
rsp_err_o  out  1  resp[1] of the R or B beat
aw_valid_o/aw_ready_i/aw_addr_o/aw_id_o  mixed  1/1/ADDR_W/ID_W  AXI AW channel
w_valid_o/w_ready_i/w_data_o/w_strb_o/w_last_o  mixed  1/1/64/8/1  AXI W channel
b_valid_i/b_ready_o/b_resp_i/b_id_i  mixed  1/1/2/ID_W  AXI B channel
ar_valid_o/ar_ready_i/ar_addr_o/ar_id_o  mixed  1/1/ADDR_W/ID_W  AXI AR channel
r_valid_i/r_ready_o/r_data_i/r_resp_i/r_last_i  mixed  1/1/64/2/1  AXI R channel
Constant outputs: len 0, size 3'b011, burst 2'b01 (INCR), lock/cache/prot/qos/region/user 0.

Behaviour:
- Reset: single clock clk_i; reset rst_ni is asynchronous and active-low. On reset:
  - all *_valid_o, req_ready_o, rsp_valid_o, b_ready_o and r_ready_o are 0;
  - rsp_rdata_o and rsp_err_o are 0;
  - the round-robin pointer is 0 and the FSM is in IDLE.
- Reset mid-transaction abandons the transaction. The pending response is never delivered.
- Requester contract: hold we/addr/wdata stable while valid is high, until ready.
- IDLE:
  - Winner = first asserted req_valid_i at or after the pointer, wrapping modulo NREQ.
  - req_ready_o[winner] is a combinational 1-cycle pulse. On that edge, latch id, we, addr with [2:0] forced to 0, and wdata.
  - Pointer becomes winner+1, wrapping at NREQ.
  - Next state is AW_W if we=1, otherwise AR. With no valid, stay in IDLE.
- AR: ar_valid_o=1 with the latched addr and id. On ar_ready_i go to R.
- R:
  - r_ready_o=1.
  - Beats without r_last_i are accepted and discarded.
  - On r_valid_i & r_last_i: register r_data_i into rsp_rdata_o, r_resp_i[1] into rsp_err_o, and pulse rsp_valid_o[id] in the next cycle; go to IDLE.
- AW_W:
  - aw_valid_o and w_valid_o assert together. w_strb_o=8'hFF, w_last_o=1.
  - Flags aw_done and w_done record each handshake; each valid drops after its own handshake.
  - When both are done (same or different cycles), go to B.
- B:
  - b_ready_o=1.
  - On b_valid_i: rsp_err_o = b_resp_i[1]; rsp_rdata_o keeps its previous value; pulse rsp_valid_o[id] in the next cycle; go to IDLE.
  - b_id_i is not checked.
- Timing:
  - Best-case load: accept at cycle 0, AR at cycle 1, R at cycle 2, rsp_valid at cycle 3.
  - Best-case store: accept at cycle 0, AW+W at cycle 1, B at cycle 2, rsp_valid at cycle 3.
  - A new accept can happen in the same cycle rsp_valid is high, because the FSM is already back in IDLE.
- Simultaneous requests: strict round-robin. No requester is granted twice while another is waiting.
- Exactly one outstanding transaction at any time, so AXI ordering needs no tracking.

Decomposition:
- Package jtag_axi_pkg:
  - FSM state enum: IDLE, AR, R, AW_W, B.
  - Constants: AXI_SIZE_64=3'b011, AXI_BURST_INCR=2'b01, AXI_STRB_ALL=8'hFF.
  - RESP_OKAY, RESP_SLVERR, RESP_DECERR.
- Sub-module jtag_axi_rr_arb: combinational round-robin winner select.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, winner index, any-valid.

Test Plan:
- Requester 0 load at 0x1000_0005; slave returns ar_ready immediately, r_data=64'hDEAD_BEEF_0123_4567, OKAY -> ar_addr_o=0x1000_0000, ar_id_o=0, rsp_valid_o=2'b01 at cycle 3, rsp_err_o=0.
- Requester 1 store 64'hA5A5 to 0x20; slave accepts W 3 cycles before AW -> a single AW and a single W handshake, b_ready_o rises only after both, rsp_valid_o=2'b10.
- Both requesters held valid for 4 back-to-back transfers starting with pointer=0 -> grant order 0,1,0,1.
- Load whose R beat has resp=SLVERR (2'b10) -> rsp_err_o=1; the following OKAY store -> rsp_err_o=0.
- rst_ni asserted low while in R -> all valids/readys 0 immediately; after release no rsp_valid_o pulse and the next grant goes to requester 0.
- R channel delivers 2 beats, only the second with last=1 -> rsp_rdata_o equals the second beat's data, exactly one rsp pulse.

Source files
------------

// File: rtl/jtag_axi_arbiter_pkg.sv
// Shared types and AXI constants for the debug-requester AXI arbiter.
package jtag_axi_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW_W = 3'd3,
        B    = 3'd4
    } state_e;

    localparam logic [7:0] AXI_LEN_SINGLE = 8'h00;
    localparam logic [2:0] AXI_SIZE_64    = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_STRB_ALL   = 8'hFF;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/jtag_axi_arbiter_if.sv
// 64-bit AXI4 master/slave bundle used on the arbiter's crossbar side.
interface jtag_axi_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
);
    logic              aw_valid;
    logic              aw_ready;
    logic [ADDR_W-1:0] aw_addr;
    logic [ID_W-1:0]   aw_id;
    logic [7:0]        aw_len;
    logic [2:0]        aw_size;
    logic [1:0]        aw_burst;
    logic              aw_lock;
    logic [3:0]        aw_cache;
    logic [2:0]        aw_prot;
    logic [3:0]        aw_qos;
    logic [3:0]        aw_region;
    logic              aw_user;

    logic              w_valid;
    logic              w_ready;
    logic [63:0]       w_data;
    logic [7:0]        w_strb;
    logic              w_last;

    logic              b_valid;
    logic              b_ready;
    logic [1:0]        b_resp;
    logic [ID_W-1:0]   b_id;

    logic              ar_valid;
    logic              ar_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic [ID_W-1:0]   ar_id;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;
    logic              ar_lock;
    logic [3:0]        ar_cache;
    logic [2:0]        ar_prot;
    logic [3:0]        ar_qos;
    logic [3:0]        ar_region;
    logic              ar_user;

    logic              r_valid;
    logic              r_ready;
    logic [63:0]       r_data;
    logic [1:0]        r_resp;
    logic              r_last;

    modport master (
        output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst, aw_lock,
               aw_cache, aw_prot, aw_qos, aw_region, aw_user,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_resp, b_id,
        output b_ready,
        output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_lock,
               ar_cache, ar_prot, ar_qos, ar_region, ar_user,
        input  ar_ready,
        input  r_valid, r_data, r_resp, r_last,
        output r_ready
    );

    modport slave (
        input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst, aw_lock,
               aw_cache, aw_prot, aw_qos, aw_region, aw_user,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_resp, b_id,
        input  b_ready,
        input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_lock,
               ar_cache, ar_prot, ar_qos, ar_region, ar_user,
        output ar_ready,
        output r_valid, r_data, r_resp, r_last,
        input  r_ready
    );

endinterface

// File: rtl/jtag_axi_arbiter_rr_arb.sv
// Combinational round-robin pick: first asserted request at or after the pointer.
module jtag_axi_rr_arb #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int cand;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr_i) + k) % NREQ;
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/jtag_axi_arbiter.sv
// Shares one 64-bit AXI master among NREQ debug requesters, one single-beat
// transaction at a time, with round-robin command acceptance.
module jtag_axi_arbiter
    import jtag_axi_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NREQ-1:0]        req_valid_i,
    output logic [NREQ-1:0]        req_ready_o,
    input  logic [NREQ-1:0]        req_we_i,
    input  logic [NREQ*ADDR_W-1:0] req_addr_i,
    input  logic [NREQ*64-1:0]     req_wdata_i,
    output logic [NREQ-1:0]        rsp_valid_o,
    output logic [63:0]            rsp_rdata_o,
    output logic                   rsp_err_o,
    jtag_axi_arbiter_if.master     axi
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e            state_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  ptr_d;
    logic [IDX_W-1:0]  id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;
    logic              ar_valid_q;
    logic              aw_valid_q;
    logic              w_valid_q;
    logic              aw_done_q;
    logic              w_done_q;
    logic              b_ready_q;
    logic              r_ready_q;
    logic [NREQ-1:0]   rsp_valid_q;
    logic [63:0]       rsp_rdata_q;
    logic              rsp_err_q;

    logic [NREQ-1:0]   win_gnt;
    logic [IDX_W-1:0]  win_idx;
    logic              win_any;
    logic              accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [63:0]       sel_wdata;
    logic              aw_hs;
    logic              w_hs;
    logic              aw_fin;
    logic              w_fin;
    logic              unused_inputs;

    jtag_axi_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_arb (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (win_gnt),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    assign accept      = (state_q == IDLE) && win_any;
    assign req_ready_o = accept ? win_gnt : '0;
    assign ptr_d       = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);

    assign sel_we    = req_we_i[win_idx];
    assign sel_addr  = req_addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata_i[int'(win_idx)*64 +: 64];

    assign aw_hs  = aw_valid_q && axi.aw_ready;
    assign w_hs   = w_valid_q && axi.w_ready;
    assign aw_fin = aw_done_q || aw_hs;
    assign w_fin  = w_done_q || w_hs;

    // Response ID and the low response bit carry no information for a single-outstanding master.
    assign unused_inputs = ^{axi.b_id, axi.b_resp[0], axi.r_resp[0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            ar_valid_q  <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            b_ready_q   <= 1'b0;
            r_ready_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            // NOTE: the latched command is reset as well so the AXI address/ID/data outputs are defined out of reset.
            id_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees this cycle's register values.
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (win_any) begin
                        id_q    <= win_idx;
                        addr_q  <= {sel_addr[ADDR_W-1:3], 3'b000};
                        wdata_q <= sel_wdata;
                        ptr_q   <= ptr_d;
                        if (sel_we) begin
                            state_q    <= AW_W;
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            aw_done_q  <= 1'b0;
                            w_done_q   <= 1'b0;
                        end else begin
                            state_q    <= AR;
                            ar_valid_q <= 1'b1;
                        end
                    end
                end
                AR: begin
                    if (axi.ar_ready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state_q    <= R;
                    end
                end
                R: begin
                    // Non-last beats are consumed and dropped; only the last beat answers.
                    if (axi.r_valid && axi.r_last) begin
                        rsp_rdata_q <= axi.r_data;
                        rsp_err_q   <= axi.r_resp[1];
                        rsp_valid_q <= NREQ'(1) << id_q;
                        r_ready_q   <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                AW_W: begin
                    if (aw_hs) begin
                        aw_valid_q <= 1'b0;
                        aw_done_q  <= 1'b1;
                    end
                    if (w_hs) begin
                        w_valid_q <= 1'b0;
                        w_done_q  <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        b_ready_q <= 1'b1;
                        state_q   <= B;
                    end
                end
                B: begin
                    if (axi.b_valid) begin
                        rsp_err_q   <= axi.b_resp[1];
                        rsp_valid_q <= NREQ'(1) << id_q;
                        b_ready_q   <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

    assign axi.aw_valid  = aw_valid_q;
    assign axi.aw_addr   = addr_q;
    assign axi.aw_id     = ID_W'(id_q);
    assign axi.aw_len    = AXI_LEN_SINGLE;
    assign axi.aw_size   = AXI_SIZE_64;
    assign axi.aw_burst  = AXI_BURST_INCR;
    assign axi.aw_lock   = 1'b0;
    assign axi.aw_cache  = 4'h0;
    assign axi.aw_prot   = 3'h0;
    assign axi.aw_qos    = 4'h0;
    assign axi.aw_region = 4'h0;
    assign axi.aw_user   = 1'b0;

    assign axi.w_valid = w_valid_q;
    assign axi.w_data  = wdata_q;
    assign axi.w_strb  = AXI_STRB_ALL;
    assign axi.w_last  = 1'b1;

    assign axi.b_ready = b_ready_q;

    assign axi.ar_valid  = ar_valid_q;
    assign axi.ar_addr   = addr_q;
    assign axi.ar_id     = ID_W'(id_q);
    assign axi.ar_len    = AXI_LEN_SINGLE;
    assign axi.ar_size   = AXI_SIZE_64;
    assign axi.ar_burst  = AXI_BURST_INCR;
    assign axi.ar_lock   = 1'b0;
    assign axi.ar_cache  = 4'h0;
    assign axi.ar_prot   = 3'h0;
    assign axi.ar_qos    = 4'h0;
    assign axi.ar_region = 4'h0;
    assign axi.ar_user   = 1'b0;

    assign axi.r_ready = r_ready_q;

endmodule

// File: tb/tb_jtag_axi_arbiter.sv
// Directed bench for jtag_axi_arbiter: table of best-case transactions plus
// hand sequences for split AW/W, round-robin, reset in R and multi-beat R.
module tb_jtag_axi_arbiter;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;

    typedef struct {
        int          req;
        logic        we;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [1:0]  resp;
        logic [63:0] rdata;
        logic [31:0] exp_addr;
        logic        exp_err;
        logic [63:0] exp_rdata;
    } vec_t;

    logic                   clk;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*64-1:0]     req_wdata;
    logic [NREQ-1:0]        rsp_valid;
    logic [63:0]            rsp_rdata;
    logic                   rsp_err;

    int n_tests = 0;
    int n_fail  = 0;
    int aw_cnt  = 0;
    int w_cnt   = 0;
    int rsp_cnt = 0;

    vec_t vecs[5];

    jtag_axi_arbiter_if #(.ADDR_W(ADDR_W), .ID_W(ID_W)) axi ();

    jtag_axi_arbiter #(
        .NREQ   (NREQ),
        .ADDR_W (ADDR_W),
        .ID_W   (ID_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .axi         (axi.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
        $fatal(1);
    end

    always @(posedge clk) begin
        if (axi.aw_valid && axi.aw_ready) aw_cnt++;
        if (axi.w_valid && axi.w_ready) w_cnt++;
        if (rsp_valid != '0) rsp_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        oh = NREQ'(1) << i;
    endfunction

    task automatic clear_slave();
        axi.aw_ready = 1'b0;
        axi.w_ready  = 1'b0;
        axi.b_valid  = 1'b0;
        axi.b_resp   = 2'b00;
        axi.b_id     = '0;
        axi.ar_ready = 1'b0;
        axi.r_valid  = 1'b0;
        axi.r_data   = '0;
        axi.r_resp   = 2'b00;
        axi.r_last   = 1'b0;
    endtask

    task automatic set_req(input int r, input logic we, input logic [31:0] addr, input logic [63:0] wdata);
        req_we[r]               = we;
        req_addr[r*ADDR_W +: ADDR_W] = addr;
        req_wdata[r*64 +: 64]   = wdata;
        req_valid[r]            = 1'b1;
    endtask

    // Best-case transaction: accept c0, address/data c1, response beat c2, rsp_valid c3.
    task automatic run_vector(input vec_t v);
        set_req(v.req, v.we, v.addr, v.wdata);
        #1 check("accept_onehot", {62'd0, req_ready}, {62'd0, oh(v.req)});
        @(negedge clk);
        req_valid = '0;
        #1;
        if (!v.we) begin
            check("ar_aw_valid", {62'd0, axi.ar_valid, axi.aw_valid}, 64'b10);
            check("ar_addr", {32'd0, axi.ar_addr}, {32'd0, v.exp_addr});
            check("ar_id", {60'd0, axi.ar_id}, 64'(v.req));
            axi.ar_ready = 1'b1;
        end else begin
            check("aw_w_valid", {61'd0, axi.ar_valid, axi.aw_valid, axi.w_valid}, 64'b011);
            check("aw_addr", {32'd0, axi.aw_addr}, {32'd0, v.exp_addr});
            check("aw_id", {60'd0, axi.aw_id}, 64'(v.req));
            check("w_data", axi.w_data, v.wdata);
            check("w_strb_last", {55'd0, axi.w_strb, axi.w_last}, {55'd0, 8'hFF, 1'b1});
            axi.aw_ready = 1'b1;
            axi.w_ready  = 1'b1;
        end
        @(negedge clk);
        clear_slave();
        #1;
        if (!v.we) begin
            check("r_ready", {63'd0, axi.r_ready}, 64'd1);
            axi.r_valid = 1'b1;
            axi.r_last  = 1'b1;
            axi.r_data  = v.rdata;
            axi.r_resp  = v.resp;
        end else begin
            check("b_ready", {63'd0, axi.b_ready}, 64'd1);
            axi.b_valid = 1'b1;
            axi.b_resp  = v.resp;
            axi.b_id    = ID_W'(v.req);
        end
        @(negedge clk);
        clear_slave();
        #1;
        check("rsp_valid", {62'd0, rsp_valid}, {62'd0, oh(v.req)});
        check("rsp_err", {63'd0, rsp_err}, {63'd0, v.exp_err});
        check("rsp_rdata", rsp_rdata, v.exp_rdata);
        @(negedge clk);
        #1 check("rsp_single_pulse", {62'd0, rsp_valid}, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [NREQ-1:0] grants[4];
        logic [NREQ-1:0] exp_grants[4];
        int got;
        int budget;
        int aw_base;
        int w_base;
        int rsp_base;
        logic found;

        vecs[0] = '{req: 0, we: 1'b0, addr: 32'h1000_0005, wdata: 64'h0, resp: 2'b00,
                    rdata: 64'hDEAD_BEEF_0123_4567, exp_addr: 32'h1000_0000, exp_err: 1'b0,
                    exp_rdata: 64'hDEAD_BEEF_0123_4567};
        vecs[1] = '{req: 1, we: 1'b0, addr: 32'h0000_0ABF, wdata: 64'h0, resp: 2'b10,
                    rdata: 64'h0123_4567_89AB_CDEF, exp_addr: 32'h0000_0AB8, exp_err: 1'b1,
                    exp_rdata: 64'h0123_4567_89AB_CDEF};
        vecs[2] = '{req: 0, we: 1'b1, addr: 32'h0000_0008, wdata: 64'h0000_0000_0000_5555, resp: 2'b00,
                    rdata: 64'h0, exp_addr: 32'h0000_0008, exp_err: 1'b0,
                    exp_rdata: 64'h0123_4567_89AB_CDEF};
        vecs[3] = '{req: 1, we: 1'b1, addr: 32'h0000_0047, wdata: 64'hCAFE_F00D_0000_0001, resp: 2'b11,
                    rdata: 64'h0, exp_addr: 32'h0000_0040, exp_err: 1'b1,
                    exp_rdata: 64'h0123_4567_89AB_CDEF};
        vecs[4] = '{req: 0, we: 1'b0, addr: 32'h0000_3001, wdata: 64'h0, resp: 2'b01,
                    rdata: 64'hFFFF_0000_FFFF_0000, exp_addr: 32'h0000_3000, exp_err: 1'b0,
                    exp_rdata: 64'hFFFF_0000_FFFF_0000};
        exp_grants = '{2'b01, 2'b10, 2'b01, 2'b10};

        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        clear_slave();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_valids", {55'd0, axi.ar_valid, axi.aw_valid, axi.w_valid, axi.b_ready,
                               axi.r_ready, req_ready, rsp_valid}, 64'd0);
        check("reset_rsp", {rsp_rdata[62:0], rsp_err}, 64'd0);
        check("const_ar", {51'd0, axi.ar_len, axi.ar_size, axi.ar_burst}, {51'd0, 8'h00, 3'b011, 2'b01});
        check("const_aw", {51'd0, axi.aw_len, axi.aw_size, axi.aw_burst}, {51'd0, 8'h00, 3'b011, 2'b01});
        check("const_zero", {14'd0, axi.aw_lock, axi.aw_cache, axi.aw_prot, axi.aw_qos, axi.aw_region,
                             axi.aw_user, axi.ar_lock, axi.ar_cache, axi.ar_prot, axi.ar_qos,
                             axi.ar_region, axi.ar_user}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vector(vecs[i]);

        // Store from requester 1 where W is accepted three cycles before AW
        aw_base = aw_cnt;
        w_base  = w_cnt;
        set_req(1, 1'b1, 32'h0000_0020, 64'h0000_0000_0000_A5A5);
        #1 check("split_accept", {62'd0, req_ready}, 64'b10);
        @(negedge clk);
        req_valid = '0;
        #1 check("split_both_valid", {61'd0, axi.aw_valid, axi.w_valid, axi.b_ready}, 64'b110);
        check("split_w_data", axi.w_data, 64'h0000_0000_0000_A5A5);
        axi.w_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            axi.w_ready = 1'b0;
            #1 check("split_wait_aw", {61'd0, axi.aw_valid, axi.w_valid, axi.b_ready}, 64'b100);
        end
        axi.aw_ready = 1'b1;
        @(negedge clk);
        axi.aw_ready = 1'b0;
        #1 check("split_b_ready", {61'd0, axi.aw_valid, axi.w_valid, axi.b_ready}, 64'b001);
        check("split_aw_count", 64'(aw_cnt - aw_base), 64'd1);
        check("split_w_count", 64'(w_cnt - w_base), 64'd1);
        axi.b_valid = 1'b1;
        axi.b_resp  = 2'b00;
        @(negedge clk);
        clear_slave();
        #1 check("split_rsp_valid", {62'd0, rsp_valid}, 64'b10);
        check("split_rsp_err", {63'd0, rsp_err}, 64'd0);
        check("split_rdata_kept", rsp_rdata, 64'hFFFF_0000_FFFF_0000);
        @(negedge clk);

        // Both requesters held valid: strict alternation starting from requester 0
        set_req(0, 1'b0, 32'h0000_0100, 64'h0);
        set_req(1, 1'b0, 32'h0000_0200, 64'h0);
        axi.ar_ready = 1'b1;
        axi.r_valid  = 1'b1;
        axi.r_last   = 1'b1;
        axi.r_data   = 64'h0000_0000_0000_0077;
        got    = 0;
        budget = 0;
        while (got < 4 && budget < 40) begin
            #1;
            if (req_ready != '0) begin
                grants[got] = req_ready;
                if (got > 0) check("rr_rsp_with_accept", {62'd0, rsp_valid}, {62'd0, grants[got-1]});
                got++;
            end
            @(negedge clk);
            budget++;
        end
        req_valid = '0;
        check("rr_grant_count", 64'(got), 64'd4);
        for (int i = 0; i < got; i++) check("rr_grant_order", {62'd0, grants[i]}, {62'd0, exp_grants[i]});
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            #1;
            if (rsp_valid != '0) found = 1'b1;
            @(negedge clk);
        end
        check("rr_last_rsp_seen", {63'd0, found}, 64'd1);
        clear_slave();
        @(negedge clk);

        // Reset while in R: transaction abandoned, pointer back to 0
        set_req(0, 1'b0, 32'h0000_0500, 64'h0);
        #1 check("rst_accept", {62'd0, req_ready}, 64'b01);
        @(negedge clk);
        req_valid = '0;
        #1 axi.ar_ready = 1'b1;
        @(negedge clk);
        axi.ar_ready = 1'b0;
        #1 check("rst_in_r", {63'd0, axi.r_ready}, 64'd1);
        rsp_base = rsp_cnt;
        rst_n = 1'b0;
        #1;
        check("rst_valids", {55'd0, axi.ar_valid, axi.aw_valid, axi.w_valid, axi.b_ready,
                             axi.r_ready, req_ready, rsp_valid}, 64'd0);
        check("rst_rsp_regs", {rsp_rdata[62:0], rsp_err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_no_rsp", 64'(rsp_cnt - rsp_base), 64'd0);

        // After reset: grant to requester 0, then a two-beat R burst
        set_req(0, 1'b0, 32'h0000_0500, 64'h0);
        set_req(1, 1'b0, 32'h0000_0608, 64'h0);
        #1 check("rst_ptr_grant", {62'd0, req_ready}, 64'b01);
        @(negedge clk);
        req_valid = '0;
        #1 check("mb_ar_addr", {32'd0, axi.ar_addr}, 64'h0000_0500);
        axi.ar_ready = 1'b1;
        @(negedge clk);
        axi.ar_ready = 1'b0;
        axi.r_valid  = 1'b1;
        axi.r_last   = 1'b0;
        axi.r_resp   = 2'b10;
        axi.r_data   = 64'h1111_AAAA_1111_AAAA;
        @(negedge clk);
        axi.r_last = 1'b1;
        axi.r_resp = 2'b00;
        axi.r_data = 64'h2222_BBBB_2222_BBBB;
        #1 check("mb_no_rsp_first_beat", {62'd0, rsp_valid}, 64'd0);
        check("mb_still_ready", {63'd0, axi.r_ready}, 64'd1);
        @(negedge clk);
        clear_slave();
        #1 check("mb_rsp_valid", {62'd0, rsp_valid}, 64'b01);
        check("mb_rdata", rsp_rdata, 64'h2222_BBBB_2222_BBBB);
        check("mb_err", {63'd0, rsp_err}, 64'd0);
        repeat (3) @(negedge clk);
        check("mb_one_pulse", 64'(rsp_cnt - rsp_base), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
